// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory fetch handshake between the sequencer and imem.
//   req   - fetch request, held high until ack
//   addr  - fetch word address
//   ack   - fetch complete; rdata valid in the same cycle
//   rdata - fetched 32-bit instruction
interface instr_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                req;
    logic [PC_WIDTH-1:0] addr;
    logic                ack;
    logic [31:0]         rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/exec/writeback control sequencer for a simple core.
//   clk, rst_n         - rising-edge clock, synchronous active-low reset
//   imem               - fetch handshake (master side)
//   start, stop        - begin/resume sequencing; return to IDLE after the current WB
//   instr              - latched instruction for the external decoder
//   dec_reg_write      - decoder register-write flag
//   dec_opsel          - decoder ALU select
//   alu_opsel          - registered ALU select, stable from DECODE through WB
//   rf_we              - one-cycle register-file write strobe in WB
//   busy, halted       - activity / HALT status
//   pc, instr_count    - program counter and saturating retired-instruction count
module instr_sequencer #(
    parameter int         PC_WIDTH    = 8,
    parameter int         MUL_CYCLES  = 3,
    parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_sequencer_if.master   imem,
    input  logic                start,
    input  logic                stop,
    output logic [31:0]         instr,
    input  logic                dec_reg_write,
    input  logic [3:0]          dec_opsel,
    output logic [3:0]          alu_opsel,
    output logic                rf_we,
    output logic                busy,
    output logic                halted,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [3:0] MUL_OPSEL = 4'b1101;

    state_t     state_q, state_d;
    logic [3:0] cnt;
    logic       we_q;
    logic       is_halt;
    logic       writes;

    assign is_halt = instr[6:0] == HALT_OPCODE;
    // Only R-type and I-type ALU opcodes may write the register file.
    assign writes  = dec_reg_write && (instr[6:0] == 7'b0110011 || instr[6:0] == 7'b0010011);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = imem.ack ? DECODE : FETCH;
            DECODE:  state_d = is_halt ? HALT : EXEC;
            EXEC:    state_d = cnt == 4'd0 ? WB : EXEC;
            WB:      state_d = stop ? IDLE : FETCH;
            HALT:    state_d = start ? FETCH : HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem.req  = state_q == FETCH;
    assign imem.addr = pc;
    assign rf_we     = state_q == WB && we_q;
    assign busy      = state_q != IDLE && state_q != HALT;
    assign halted    = state_q == HALT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc          <= '0;
            instr       <= '0;
            alu_opsel   <= 4'b0000;
            instr_count <= '0;
            cnt         <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem.ack)
                instr <= imem.rdata;
            if (state_q == DECODE && !is_halt) begin
                alu_opsel <= dec_opsel;
                we_q      <= writes;
                // Counter holds the number of EXEC cycles remaining after the current one.
                cnt       <= dec_opsel == MUL_OPSEL ? 4'(MUL_CYCLES - 1) : 4'd0;
            end
            if (state_q == EXEC && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state_q == WB) begin
                pc <= pc + 1'b1;
                if (instr_count != 16'hFFFF)
                    instr_count <= instr_count + 16'd1;
            end
            if (state_q == HALT && start)
                pc <= '0;
        end
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8: instruction-memory word-address width.
REQ-002 SHALL have parameter MUL_CYCLES, default 3: EXEC cycles for Opsel 4'b1101 (MUL); legal range 1..15.
REQ-003 SHALL have parameter HALT_OPCODE, default 7'b1111111: opcode that halts the sequencer.
REQ-004 SHALL have one clock and a synchronous, active-low reset; the ports are clk (in, 1, rising-edge clock) and rst_n (in, 1, synchronous active-low reset).
REQ-005 start  in  1  begin or resume sequencing; honoured only in IDLE and HALT.
REQ-006 stop  in  1  sampled in WB; when high, return to IDLE after the current instruction.
REQ-007 imem_req  out  1  instruction fetch request.
REQ-008 imem_addr  out  PC_WIDTH  fetch word address, equal to pc.
REQ-009 imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  fetched instruction.
REQ-011 instr  out  32  latched instruction, fed to the decoder.
REQ-012 dec_reg_write  in  1  decoder register-write flag.
REQ-013 dec_opsel  in  4  decoder ALU select.
REQ-014 alu_opsel  out  4  registered ALU select driven to the datapath.
REQ-015 rf_we  out  1  register-file write strobe, one cycle wide.
REQ-016 busy  out  1  high in every state except IDLE and HALT.
REQ-017 halted  out  1  high in HALT.
REQ-018 pc  out  PC_WIDTH  current program counter.
REQ-019 instr_count  out  16  count of retired instructions.

Function
REQ-020 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB and HALT, all registered.
REQ-021 IDLE: start=1 -> FETCH; pc unchanged.
REQ-022 FETCH: drive imem_req=1 and imem_addr=pc, both held stable until imem_ack; on imem_ack: instr<=imem_rdata, drop imem_req next cycle, -> DECODE.
REQ-023 DECODE (1 cycle): if instr[6:0]==HALT_OPCODE -> HALT with no retire and pc unchanged; else alu_opsel<=dec_opsel and latch the write enable (see REQ-024), -> EXEC.
REQ-024 Latched write enable = dec_reg_write AND (instr[6:0]==7'b0110011 OR instr[6:0]==7'b0010011); every other opcode never writes.
REQ-025 EXEC: 1 cycle, or MUL_CYCLES cycles when alu_opsel==4'b1101, counted by an internal down-counter; alu_opsel held stable for the whole of EXEC; then -> WB.
REQ-026 WB (1 cycle): rf_we=latched write enable; pc<=pc+1 modulo 2^PC_WIDTH (all-ones wraps to 0); instr_count<=instr_count+1, saturating at 16'hFFFF; stop=1 -> IDLE, else -> FETCH.
REQ-027 HALT: halted=1; start=1 -> FETCH with pc<=0 and halted cleared the next cycle; instr_count is kept.
REQ-028 start while busy=1 SHALL be ignored; stop outside WB SHALL be ignored (not remembered).
REQ-029 Latency with imem_ack in the first FETCH cycle: 4 cycles per non-MUL instruction and 3+MUL_CYCLES cycles per MUL, measured FETCH entry to FETCH entry.
REQ-030 rf_we SHALL never be high outside WB; imem_req SHALL never be high outside FETCH.
REQ-031 alu_opsel SHALL keep its last value in IDLE and HALT.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force state=IDLE, pc=0, instr=0, alu_opsel=4'b0000, instr_count=0, and imem_req=rf_we=busy=halted=0; the EXEC counter and latched write enable SHALL clear.
REQ-033 Reset mid-operation (including mid-fetch or mid-MUL) SHALL abort immediately with no rf_we pulse; an imem_ack arriving in the reset cycle SHALL be ignored.

Verification
REQ-034 ADD (opcode 0110011, funct7=0, funct3=0), ack in the same cycle, start pulsed from reset -> imem_req at cycle 1; rf_we=1 at cycle 4 with alu_opsel=0000; pc=1; instr_count=1.
REQ-035 MUL (funct7=0, funct3=2), MUL_CYCLES=3 -> alu_opsel=1101 held for 3 EXEC cycles; single rf_we pulse; next FETCH 6 cycles after the previous one.
REQ-036 Opcode 0100011 with dec_reg_write=1 -> no rf_we, pc increments, instr_count increments; imem_ack delayed 5 cycles -> imem_req and imem_addr held stable throughout.
REQ-037 HALT_OPCODE at pc=7 -> halted=1, busy=0, pc=7, instr_count unchanged; start -> FETCH at pc=0.
REQ-038 PC_WIDTH=8, pc=8'hFF, stop=1 in WB -> pc=0, state IDLE, busy=0; rst_n=0 mid-MUL -> all outputs at reset values the next cycle and no rf_we.
